// File: rtl/ram_nr1w_clr.sv
// N-read / 1-write synchronous RAM with registered reads, write-first forwarding,
// read-before-write readback on the write port and a sequential clear sweep.
module ram_nr1w_clr #(
    parameter int unsigned    DW       = 32,
    parameter int unsigned    AW       = 11,
    parameter int unsigned    NR       = 2,
    parameter logic [DW-1:0]  INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_req,
    output logic             busy,
    input  logic             we,
    input  logic [AW-1:0]    addrw,
    input  logic [DW-1:0]    dinw,
    output logic [DW-1:0]    doutw,
    input  logic [NR-1:0]    re,
    input  logic [NR*AW-1:0] addr_r,
    output logic [NR*DW-1:0] dout_r,
    output logic [NR-1:0]    rvalid
);

    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;

    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [DW-1:0]   mem_wd;
    logic            wr_acc;
    logic [NR-1:0]   rd_acc;

    logic [DW-1:0]   mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // The single array write port is shared between the sweep and the user port.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy    = 1'b0;
        mem_we  = 1'b0;
        mem_wa  = addrw;
        mem_wd  = dinw;
        wr_acc  = 1'b0;
        rd_acc  = '0;
        case (state_q)
            CLEAR: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                mem_wa = ptr_q;
                mem_wd = INIT_VAL;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == '1) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end else begin
                    wr_acc = we;
                    mem_we = we;
                    rd_acc = re;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            doutw  <= '0;
            dout_r <= '0;
            rvalid <= '0;
        end else begin
            rvalid <= rd_acc;
            if (wr_acc) begin
                doutw <= mem[addrw];
            end
            for (int unsigned i = 0; i < NR; i++) begin
                if (rd_acc[i]) begin
                    if (wr_acc && (addrw == addr_r[i*AW +: AW])) begin
                        dout_r[i*DW +: DW] <= dinw;
                    end else begin
                        dout_r[i*DW +: DW] <= mem[addr_r[i*AW +: AW]];
                    end
                end
            end
        end
    end

endmodule
